// File: rtl/entry_seq_ctrl.sv
// -----------------------------------------------------------------------------
// entry_seq_ctrl
//
// Sequencing controller for the operator BCD entry datapath. KEY[0] is
// synchronised and debounced. Each accepted press steps the entry through the
// ones, tens, hundreds and (optionally) sign digits. SW[3:0]/SW[9] are captured
// into shadow registers on each press. A complete value is copied atomically
// into the committed outputs, and a one-cycle commit pulse marks that copy.
// The module also drives the digit-select and blink-phase signals that the
// 7-seg muxes use to flash the digit being edited.
//
// Build option:
//   ENTRY_SIGN_EN : when defined, the SIGN entry step is present. When
//                   undefined, a valid hundreds press commits directly,
//                   sign_out is tied to 0 and sign_sw is ignored.
//
// Parameters:
//   DEB_CNT   : consecutive stable cycles needed to accept a key level change
//   BLINK_CNT : cycles per blink half-period
//
// Ports:
//   clk        in   CLOCK_50; all registers use the rising edge
//   rst        in   synchronous, active-high reset
//   key_n      in   raw KEY[0], active-low, asynchronous
//   bcd_num    in   [3:0] digit value from SW[3:0]
//   sign_sw    in   sign from SW[9] (1 = negative)
//   ones_out   out  [3:0] committed ones digit
//   tens_out   out  [3:0] committed tens digit
//   huns_out   out  [3:0] committed hundreds digit
//   sign_out   out  committed sign
//   digit_sel  out  [1:0] digit being edited (0 ones, 1 tens, 2 huns, 3 sign/done)
//   blink      out  1 = show the selected digit, 0 = blank it
//   commit     out  one-cycle pulse when new committed values first appear
//   entry_err  out  one-cycle pulse when a press with bcd_num > 9 is rejected
// -----------------------------------------------------------------------------
module entry_seq_ctrl #(
  parameter int unsigned DEB_CNT   = 500000,
  parameter int unsigned BLINK_CNT = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_n,
  input  logic [3:0] bcd_num,
  input  logic       sign_sw,
  output logic [3:0] ones_out,
  output logic [3:0] tens_out,
  output logic [3:0] huns_out,
  output logic       sign_out,
  output logic [1:0] digit_sel,
  output logic       blink,
  output logic       commit,
  output logic       entry_err
);

  localparam int unsigned DEB_W = (DEB_CNT > 1)   ? $clog2(DEB_CNT)   : 1;
  localparam int unsigned BLK_W = (BLINK_CNT > 1) ? $clog2(BLINK_CNT) : 1;

  typedef enum logic [2:0] {
    S_ONES   = 3'd0,
    S_TENS   = 3'd1,
    S_HUNS   = 3'd2,
`ifdef ENTRY_SIGN_EN
    S_SIGN   = 3'd3,
`endif
    S_COMMIT = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  // ---------------------------------------------------------------------------
  // Key synchroniser and debouncer (level 1 = released)
  // ---------------------------------------------------------------------------
  logic [1:0]       r_sync;
  logic             r_deb;
  logic             r_deb_d1;
  logic [DEB_W-1:0] r_deb_cnt;
  logic             r_accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], key_n};
    end
  end

  // The count restarts whenever the synchronised level agrees with the
  // debounced level, so any bounce throws away the progress made so far.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_deb     <= 1'b1;
      r_deb_cnt <= '0;
    end else if (r_sync[1] == r_deb) begin
      r_deb_cnt <= '0;
    end else if (r_deb_cnt == DEB_W'(DEB_CNT - 1)) begin
      r_deb     <= r_sync[1];
      r_deb_cnt <= '0;
    end else begin
      r_deb_cnt <= r_deb_cnt + 1'b1;
    end
  end

  // accept is registered from the released->pressed edge of the debounced
  // level. Holding the key gives a single pulse, and a release gives none.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_deb_d1 <= 1'b1;
      r_accept <= 1'b0;
    end else begin
      r_deb_d1 <= r_deb;
      r_accept <= r_deb_d1 & ~r_deb;
    end
  end

  // ---------------------------------------------------------------------------
  // Entry FSM
  // ---------------------------------------------------------------------------
  state_t     r_state;
  state_t     w_next;
  logic       w_digit_ok;
  logic       w_ld_ones;
  logic       w_ld_tens;
  logic       w_ld_huns;
  logic       w_ld_sign;
  logic       w_clr_shadow;
  logic       w_err_set;
  logic [1:0] w_sel;

  assign w_digit_ok = (bcd_num <= 4'd9);

  always_comb begin
    w_next       = r_state;
    w_ld_ones    = 1'b0;
    w_ld_tens    = 1'b0;
    w_ld_huns    = 1'b0;
    w_ld_sign    = 1'b0;
    w_clr_shadow = 1'b0;
    w_err_set    = 1'b0;
    w_sel        = 2'd3;
    case (r_state)
      S_ONES: begin
        w_sel = 2'd0;
        if (r_accept) begin
          if (w_digit_ok) begin
            w_ld_ones = 1'b1;
            w_next    = S_TENS;
          end else begin
            w_err_set = 1'b1;
          end
        end
      end
      S_TENS: begin
        w_sel = 2'd1;
        if (r_accept) begin
          if (w_digit_ok) begin
            w_ld_tens = 1'b1;
            w_next    = S_HUNS;
          end else begin
            w_err_set = 1'b1;
          end
        end
      end
      S_HUNS: begin
        w_sel = 2'd2;
        if (r_accept) begin
          if (w_digit_ok) begin
            w_ld_huns = 1'b1;
`ifdef ENTRY_SIGN_EN
            w_next    = S_SIGN;
`else
            w_next    = S_COMMIT;
`endif
          end else begin
            w_err_set = 1'b1;
          end
        end
      end
`ifdef ENTRY_SIGN_EN
      S_SIGN: begin
        if (r_accept) begin
          w_ld_sign = 1'b1;
          w_next    = S_COMMIT;
        end
      end
`endif
      S_COMMIT: begin
        w_next = S_DONE;
      end
      S_DONE: begin
        if (r_accept) begin
          w_clr_shadow = 1'b1;
          w_next       = S_ONES;
        end
      end
      default: begin
        w_next = S_ONES;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_ONES;
    end else begin
      r_state <= w_next;
    end
  end

  logic r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_err_set;
    end
  end

  // ---------------------------------------------------------------------------
  // Shadow and committed digits
  // ---------------------------------------------------------------------------
  logic [3:0] r_sh_ones;
  logic [3:0] r_sh_tens;
  logic [3:0] r_sh_huns;
  logic [3:0] w_sh_ones_nxt;
  logic [3:0] w_sh_tens_nxt;
  logic [3:0] w_sh_huns_nxt;
  logic [3:0] r_ones_out;
  logic [3:0] r_tens_out;
  logic [3:0] r_huns_out;
  logic       w_ld_commit;

  assign w_ld_commit = (w_next == S_COMMIT) && (r_state != S_COMMIT);

  // The committed copy is taken from the next-shadow values. The last digit
  // (sign or hundreds) is written on the same edge that enters COMMIT, so the
  // shadow register would still hold the old value at that point.
  assign w_sh_ones_nxt = w_clr_shadow ? 4'd0 : (w_ld_ones ? bcd_num : r_sh_ones);
  assign w_sh_tens_nxt = w_clr_shadow ? 4'd0 : (w_ld_tens ? bcd_num : r_sh_tens);
  assign w_sh_huns_nxt = w_clr_shadow ? 4'd0 : (w_ld_huns ? bcd_num : r_sh_huns);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh_ones  <= '0;
      r_sh_tens  <= '0;
      r_sh_huns  <= '0;
      r_ones_out <= '0;
      r_tens_out <= '0;
      r_huns_out <= '0;
    end else begin
      r_sh_ones <= w_sh_ones_nxt;
      r_sh_tens <= w_sh_tens_nxt;
      r_sh_huns <= w_sh_huns_nxt;
      if (w_ld_commit) begin
        r_ones_out <= w_sh_ones_nxt;
        r_tens_out <= w_sh_tens_nxt;
        r_huns_out <= w_sh_huns_nxt;
      end
    end
  end

`ifdef ENTRY_SIGN_EN
  logic r_sh_sign;
  logic w_sh_sign_nxt;
  logic r_sign_out;

  assign w_sh_sign_nxt = w_clr_shadow ? 1'b0 : (w_ld_sign ? sign_sw : r_sh_sign);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh_sign  <= 1'b0;
      r_sign_out <= 1'b0;
    end else begin
      r_sh_sign <= w_sh_sign_nxt;
      if (w_ld_commit) begin
        r_sign_out <= w_sh_sign_nxt;
      end
    end
  end

  assign sign_out = r_sign_out;
`else
  logic w_unused_sign;
  assign w_unused_sign = sign_sw ^ w_ld_sign;
  assign sign_out      = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Blink timer: a state change restarts the phase so that a newly selected
  // digit is shown straight away. The restart wins over a coincident wrap.
  // ---------------------------------------------------------------------------
  logic [BLK_W-1:0] r_blink_cnt;
  logic             r_blink;
  logic             w_state_chg;

  assign w_state_chg = (w_next != r_state);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_blink_cnt <= '0;
      r_blink     <= 1'b1;
    end else if (w_state_chg) begin
      r_blink_cnt <= '0;
      r_blink     <= 1'b1;
    end else if (r_blink_cnt == BLK_W'(BLINK_CNT - 1)) begin
      r_blink_cnt <= '0;
      r_blink     <= ~r_blink;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign ones_out  = r_ones_out;
  assign tens_out  = r_tens_out;
  assign huns_out  = r_huns_out;
  assign digit_sel = w_sel;
  assign blink     = r_blink;
  assign commit    = (r_state == S_COMMIT);
  assign entry_err = r_err;

endmodule
